hwpe_kernel_adapter_mc: RTL
===========================

// Module: hwpe_kernel_adapter_mc
// PURPOSE
//  Parametrised multi-channel kernel adapter between HWPE streamers and accelerated kernel.
//  Forwards N_IN sink streams to the kernel and M_OUT kernel streams to the streamers.
//  Counts tokens per stream against programmed lengths and gates traffic beyond them.
//  Drives job-level idle/ready/done flags to the engine FSM.
// PARAMETERS
//  N_IN    3   number of input streams (1..8)
//  M_OUT   1   number of output streams (1..8)
//  DW      32  data width per stream, bits
//  CNT_W   16  token counter / length width, bits
// PORTS
//  clk_i            in   1            clock
//  rst_ni           in   1            async reset, active low
//  test_mode_i      in   1            test mode; no functional effect
//  start_i          in   1            job start pulse, from engine ctrl
//  clear_i          in   1            synchronous abort
//  in_len_i         in   N_IN*CNT_W   tokens expected per input stream, latched on accepted start
//  out_len_i        in   M_OUT*CNT_W  tokens expected per output stream, latched on accepted start
//  in_valid_i/in_data_i/in_ready_o       N_IN, N_IN*DW, N_IN     streamer->adapter
//  k_in_valid_o/k_in_data_o/k_in_ready_i N_IN, N_IN*DW, N_IN     adapter->kernel
//  k_out_valid_i/k_out_data_i/k_out_ready_o M_OUT, M_OUT*DW, M_OUT kernel->adapter
//  out_valid_o/out_data_o/out_ready_i    M_OUT, M_OUT*DW, M_OUT  adapter->streamer
//  idle_o           out  1            no job active
//  in_done_o        out  N_IN         input stream i has received in_len[i] tokens
//  ready_o          out  1            AND of in_done_o
//  tok_o            out  M_OUT        1-cycle pulse, registered, per output token
//  done_o           out  1            1-cycle pulse at job completion
// BEHAVIOUR
//  - Reset: state IDLE, counters/lengths 0, idle_o=1, tok_o=0, done_o=0, in_done_o=0.
//  - Data paths combinational, zero latency; valid/ready gated by en[s] = (state==RUN) && (cnt[s] < len[s]).
//    Gated stream: downstream valid=0, upstream ready=0. Handshake = valid&ready after gating.
//  - FSM IDLE -> RUN on start_i: latch lens, zero counters, idle_o=0 next cycle.
//    RUN -> DONE when every cnt[s]==len[s] (inputs and outputs).
//    DONE -> IDLE unconditionally; done_o=1 during the single DONE cycle; idle_o=1 from IDLE.
//  - start_i in RUN/DONE ignored. start_i and clear_i together: clear wins, stay/return IDLE.
//  - clear_i any state: next cycle IDLE, counters 0, no done_o.
//  - Length 0: stream disabled, counts as complete. All lengths 0: RUN lasts 1 cycle, then DONE.
//  - Counters saturate at len; never wrap. Max len = 2^CNT_W-1.
//  - tok_o[m] = registered handshake of output m (one cycle after transfer).
//  - in_done_o[i] = RUN/DONE && cnt_in[i]==len_in[i]; 0 in IDLE.
//  - Reset asserted mid-job: immediate return to reset values; in-flight kernel data lost.
// CONFIGURATION
//  KERNEL_ADAPTER_PERF_EN defined: adds outputs perf_busy_o[31:0] (cycles in RUN) and
//  perf_stall_o[31:0] (RUN cycles with any enabled output valid&&!ready); both zeroed on
//  accepted start, hold after DONE, saturate at 2^32-1.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package hwpe_kernel_adapter_mc_pkg: state enum (IDLE,RUN,DONE), CNT_W_DEFAULT,
//  flags struct {idle, ready, done}.
//  Sub-module hwpe_kernel_adapter_chan_cnt: one gated stream + saturating counter + complete flag;
//  instantiated N_IN + M_OUT times via generate.
// TESTING
//  1 N_IN=3,M_OUT=1, lens in={4,4,4} out={4}, all ready -> 4 tok_o pulses, done_o once, idle_o back to 1.
//  2 in_len={2,5,1}, keep inputs valid 8 cycles -> exactly 2/5/1 transfers, in_ready_o drops after each; ready_o only after all three.
//  3 All lens 0, start -> no transfers, done_o exactly 2 cycles after start.
//  4 out_len={3}, out_ready_i toggled 1-0 -> 3 transfers, tok_o trails each by 1 cycle; PERF_EN: stall count = ready-low cycles with valid.
//  5 clear_i after 2 of 4 tokens -> IDLE next cycle, no done_o; new start with len 4 counts from 0.
//  6 start_i pulse during RUN and rst_ni low mid-job -> start ignored; reset restores all reset values.

Source files
------------

// File: rtl/hwpe_kernel_adapter_mc_pkg.sv
// Shared types for the multi-channel HWPE kernel adapter: job FSM states,
// default counter width and the job-level flag bundle.
package hwpe_kernel_adapter_mc_pkg;

  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic idle;
    logic ready;
    logic done;
  } flags_t;

endpackage

// File: rtl/hwpe_kernel_adapter_mc_if.sv
// Bundle of N valid/data/ready streams of DW bits each. The master drives
// valid and data; the slave drives ready.
interface hwpe_kernel_adapter_mc_if #(
  parameter int N  = 1,
  parameter int DW = 32
);

  logic [N-1:0]    valid;
  logic [N*DW-1:0] data;
  logic [N-1:0]    ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/hwpe_kernel_adapter_chan_cnt.sv
// One gated stream of the kernel adapter. The stream passes combinationally
// while the job runs and fewer than len tokens have been moved. Each transfer
// bumps a counter that stops at len, so it never wraps.
module hwpe_kernel_adapter_chan_cnt
  import hwpe_kernel_adapter_mc_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             up_valid_i,
  input  logic [DW-1:0]    up_data_i,
  output logic             up_ready_o,
  output logic             dn_valid_o,
  output logic [DW-1:0]    dn_data_o,
  input  logic             dn_ready_i,
  output logic             hs_o,
  output logic             complete_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             en;

  assign en         = run_i && (cnt_q < len_q);
  assign dn_valid_o = up_valid_i & en;
  assign up_ready_o = dn_ready_i & en;
  assign dn_data_o  = up_data_i;
  assign hs_o       = up_valid_i & dn_ready_i & en;
  assign complete_o = (cnt_q == len_q);

  // Next counter/length. An abort zeroes the count. A new job loads the
  // length and restarts the count. A transfer otherwise bumps the count.
  always_comb begin
    cnt_d = cnt_q;
    len_d = len_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = '0;
      len_d = len_i;
    end else if (hs_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and length registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      len_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  end

endmodule

// File: rtl/hwpe_kernel_adapter_mc.sv
// Multi-channel kernel adapter between HWPE streamers and an accelerated
// kernel. It moves exactly the programmed number of tokens on every stream of
// a job, then reports completion to the engine FSM.
// Optional build macro KERNEL_ADAPTER_PERF_EN adds the busy and stall
// performance counters.
module hwpe_kernel_adapter_mc
  import hwpe_kernel_adapter_mc_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int M_OUT = 1,
  parameter int DW    = 32,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   test_mode_i,
  input  logic                   start_i,
  input  logic                   clear_i,
  input  logic [N_IN*CNT_W-1:0]  in_len_i,
  input  logic [M_OUT*CNT_W-1:0] out_len_i,
  hwpe_kernel_adapter_mc_if.slave  in_s,
  hwpe_kernel_adapter_mc_if.master k_in_m,
  hwpe_kernel_adapter_mc_if.slave  k_out_s,
  hwpe_kernel_adapter_mc_if.master out_m,
  output logic                   idle_o,
  output logic [N_IN-1:0]        in_done_o,
  output logic                   ready_o,
  output logic [M_OUT-1:0]       tok_o,
  output logic                   done_o
`ifdef KERNEL_ADAPTER_PERF_EN
  ,
  output logic [31:0]            perf_busy_o,
  output logic [31:0]            perf_stall_o
`endif
);

  state_e           state_q, state_d;
  logic             run, load, all_cmp;
  logic [N_IN-1:0]  in_cmp, in_hs_unused;
  logic [M_OUT-1:0] out_cmp, out_hs, tok_q;
  flags_t           flags;
  logic             unused_test_mode;

  assign unused_test_mode = test_mode_i;

  assign load    = (state_q == IDLE) && start_i && !clear_i;
  assign run     = (state_q == RUN);
  assign all_cmp = (&in_cmp) && (&out_cmp);

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    hwpe_kernel_adapter_chan_cnt #(.DW(DW), .CNT_W(CNT_W)) u_chan (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .run_i      (run),
      .load_i     (load),
      .clear_i    (clear_i),
      .len_i      (in_len_i[i*CNT_W +: CNT_W]),
      .up_valid_i (in_s.valid[i]),
      .up_data_i  (in_s.data[i*DW +: DW]),
      .up_ready_o (in_s.ready[i]),
      .dn_valid_o (k_in_m.valid[i]),
      .dn_data_o  (k_in_m.data[i*DW +: DW]),
      .dn_ready_i (k_in_m.ready[i]),
      .hs_o       (in_hs_unused[i]),
      .complete_o (in_cmp[i])
    );
  end

  for (genvar m = 0; m < M_OUT; m++) begin : g_out
    hwpe_kernel_adapter_chan_cnt #(.DW(DW), .CNT_W(CNT_W)) u_chan (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .run_i      (run),
      .load_i     (load),
      .clear_i    (clear_i),
      .len_i      (out_len_i[m*CNT_W +: CNT_W]),
      .up_valid_i (k_out_s.valid[m]),
      .up_data_i  (k_out_s.data[m*DW +: DW]),
      .up_ready_o (k_out_s.ready[m]),
      .dn_valid_o (out_m.valid[m]),
      .dn_data_o  (out_m.data[m*DW +: DW]),
      .dn_ready_i (out_m.ready[m]),
      .hs_o       (out_hs[m]),
      .complete_o (out_cmp[m])
    );
  end

  // Job FSM next state. An abort overrides everything, including start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (all_cmp) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  // State register, plus a registered copy of the output handshakes for tok_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      tok_q   <= '0;
    end else begin
      state_q <= state_d;
      tok_q   <= out_hs;
    end
  end

  assign in_done_o   = in_cmp & {N_IN{state_q != IDLE}};
  assign flags.idle  = (state_q == IDLE);
  assign flags.ready = &in_done_o;
  assign flags.done  = (state_q == DONE);

  assign idle_o  = flags.idle;
  assign ready_o = flags.ready;
  assign done_o  = flags.done;
  assign tok_o   = tok_q;

`ifdef KERNEL_ADAPTER_PERF_EN
  logic [31:0] busy_q, stall_q;
  logic        stall;

  assign stall = run && |(out_m.valid & ~out_m.ready);

  // Busy and stall cycle counters. They restart on each accepted job, keep
  // their value after completion and stop at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= '0;
      stall_q <= '0;
    end else if (load) begin
      busy_q  <= '0;
      stall_q <= '0;
    end else if (run) begin
      if (busy_q != '1) busy_q <= busy_q + 32'd1;
      if (stall && (stall_q != '1)) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_busy_o  = busy_q;
  assign perf_stall_o = stall_q;
`endif

endmodule
